// File: rtl/scale_pixel_reader_pkg.sv
// Shared types and constants for the scaled pixel reader.
// Algorithm codes, zoom codes, source geometry and FSM encoding.
package scale_pixel_reader_pkg;

  localparam int SRC_WIDTH  = 160;
  localparam int SRC_HEIGHT = 120;
  localparam int DX_W       = 11;
  localparam int DY_W       = 10;
  localparam int TAP_W      = 3;

  typedef enum logic [1:0] {
    S_NN = 2'b00,
    S_PR = 2'b01,
    S_DC = 2'b10,
    S_BA = 2'b11
  } alg_e;

  typedef enum logic [1:0] {
    Z_X1 = 2'd0,
    Z_X2 = 2'd1,
    Z_X4 = 2'd2,
    Z_X8 = 2'd3
  } zoom_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OUT     = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Largest tap index along one axis for a block of 2^s pixels.
  function automatic logic [TAP_W-1:0] tap_mask(input logic [1:0] s);
    return TAP_W'((4'd1 << s) - 4'd1);
  endfunction

endpackage

// File: rtl/scale_addr_map.sv
// Maps an output coordinate (plus block tap) to a linear source address.
// Purely combinational; in_range flags coordinates inside the source frame.
module scale_addr_map #(
  parameter int SRC_WIDTH  = 160,
  parameter int SRC_HEIGHT = 120,
  parameter int ADDR_W     = 15
) (
  input  logic [1:0]        alg,
  input  logic [1:0]        shift,
  input  logic [10:0]       dx,
  input  logic [9:0]        dy,
  input  logic [2:0]        tx,
  input  logic [2:0]        ty,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  import scale_pixel_reader_pkg::*;

  logic [14:0] sx;
  logic [13:0] sy;

  always_comb begin
    sx = '0;
    sy = '0;
    unique case (alg_e'(alg))
      S_NN, S_PR: begin
        sx = 15'(dx >> shift);
        sy = 14'(dy >> shift);
      end
      S_DC: begin
        sx = 15'(dx) << shift;
        sy = 14'(dy) << shift;
      end
      S_BA: begin
        sx = (15'(dx) << shift) + 15'(tx);
        sy = (14'(dy) << shift) + 14'(ty);
      end
      default: begin
        sx = '0;
        sy = '0;
      end
    endcase
    in_range = (sx < 15'(SRC_WIDTH))
             && (sy < 14'(SRC_HEIGHT));
    // Constant multiply reduces to shifts and adds.
    addr = ADDR_W'(sy) * ADDR_W'(SRC_WIDTH)
         + ADDR_W'(sx);
  end

endmodule

// File: rtl/scale_pixel_reader.sv
// Walks the output raster, reads the source frame and emits scaled pixels.
// NN/PR replicate, DC decimates, BA averages a 2^s x 2^s block.
module scale_pixel_reader #(
  parameter int SRC_WIDTH  = 160,
  parameter int SRC_HEIGHT = 120,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [1:0]        ALGORITHM,
  input  logic [1:0]        SHIFT_FACTOR,
  input  logic [10:0]       IMG_WIDTH_OUT,
  input  logic [9:0]        IMG_HEIGHT_OUT,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [PIX_W-1:0]  RD_DATA,
  output logic [PIX_W-1:0]  PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              PIX_LAST,
  output logic              BUSY,
  output logic              DONE
);
  import scale_pixel_reader_pkg::*;

  localparam int ACC_W = PIX_W + 6;

  state_e            state_q, state_d;
  alg_e              alg_q, alg_d;
  logic [1:0]        s_q, s_d;
  logic [DX_W-1:0]   w_q, w_d, dx_q, dx_d;
  logic [DY_W-1:0]   h_q, h_d, dy_q, dy_d;
  logic [TAP_W-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] map_addr;
  logic              map_ok;
  logic [TAP_W-1:0]  mask;
  logic              last_tap, last_x, last_y;

  scale_addr_map #(
    .SRC_WIDTH  (SRC_WIDTH),
    .SRC_HEIGHT (SRC_HEIGHT),
    .ADDR_W     (ADDR_W)
  ) u_map (
    .alg      (alg_q),
    .shift    (s_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .tx       (tx_q),
    .ty       (ty_q),
    .addr     (map_addr),
    .in_range (map_ok)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      alg_q   <= S_NN;
      s_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      acc_q   <= '0;
      pix_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      alg_q   <= alg_d;
      s_q     <= s_d;
      w_q     <= w_d;
      h_q     <= h_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alg_d   = alg_q;
    s_d     = s_q;
    w_d     = w_q;
    h_d     = h_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    acc_d   = acc_q;
    pix_d   = pix_q;
    hold_d  = hold_q;

    mask     = tap_mask(s_q);
    last_tap = (alg_q != S_BA)
             || ((tx_q == mask) && (ty_q == mask));
    last_x   = dx_q == (w_q - 11'd1);
    last_y   = dy_q == (h_q - 10'd1);
    // First tap of a block restarts the sum.
    acc_sum  = ((tx_q == '0) && (ty_q == '0) ? '0 : acc_q)
             + ACC_W'(RD_DATA);

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          alg_d = alg_e'(ALGORITHM);
          s_d   = SHIFT_FACTOR;
          w_d   = IMG_WIDTH_OUT;
          h_d   = IMG_HEIGHT_OUT;
          dx_d  = '0;
          dy_d  = '0;
          tx_d  = '0;
          ty_d  = '0;
          acc_d = '0;
          if ((IMG_WIDTH_OUT == '0) || (IMG_HEIGHT_OUT == '0))
            state_d = ST_FIN;
          else
            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (map_ok) hold_d = map_addr;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        acc_d = acc_sum;
        if (!last_tap) begin
          if (tx_q == mask) begin
            tx_d = '0;
            ty_d = ty_q + 3'd1;
          end else begin
            tx_d = tx_q + 3'd1;
          end
          state_d = ST_ISSUE;
        end else begin
          pix_d = (alg_q == S_BA)
                ? PIX_W'(acc_sum >> {s_q, 1'b0})
                : RD_DATA;
          tx_d    = '0;
          ty_d    = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (PIX_READY) begin
          if (last_x && last_y) begin
            state_d = ST_FIN;
          end else begin
            if (last_x) begin
              dx_d = '0;
              dy_d = dy_q + 10'd1;
            end else begin
              dx_d = dx_q + 11'd1;
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign RD_EN     = state_q == ST_ISSUE;
  assign RD_ADDR   = !RD_EN ? '0 : (map_ok ? map_addr : hold_q);
  assign PIX_VALID = state_q == ST_OUT;
  assign PIX_DATA  = pix_q;
  assign PIX_LAST  = PIX_VALID && last_x && last_y;
  assign BUSY      = state_q != ST_IDLE;
  assign DONE      = state_q == ST_FIN;

endmodule
